// File: rtl/regfile_writer.sv
// Write-side front end for the integer register file: two buffered result
// sources, starvation-bounded arbitration, x0 filtering and a pending-write mask.
module regfile_writer #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            src0_valid,
  output logic            src0_ready,
  input  logic [4:0]      src0_addr,
  input  logic [XLEN-1:0] src0_data,
  input  logic            src1_valid,
  output logic            src1_ready,
  input  logic [4:0]      src1_addr,
  input  logic [XLEN-1:0] src1_data,
  output logic [4:0]      write_addr,
  output logic [XLEN-1:0] write_data,
  output logic            write_ena,
  output logic [31:0]     pending_mask
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic [4:0]      fifo_addr [2][DEPTH];
  logic [XLEN-1:0] fifo_data [2][DEPTH];
  logic [PW-1:0]   rd_ptr [2];
  logic [PW-1:0]   wr_ptr [2];
  logic [CW-1:0]   count  [2];
  logic [SW-1:0]   starve_cnt;

  logic [1:0]      in_valid;
  logic [4:0]      in_addr [2];
  logic [XLEN-1:0] in_data [2];
  logic [1:0]      ready;
  logic [1:0]      nonempty;
  logic [1:0]      push;
  logic [1:0]      grant;
  logic            starved;

  assign in_valid   = {src1_valid, src0_valid};
  assign in_addr[0] = src0_addr;
  assign in_addr[1] = src1_addr;
  assign in_data[0] = src0_data;
  assign in_data[1] = src1_data;
  assign src0_ready = ready[0];
  assign src1_ready = ready[1];

  // Handshake and arbitration; ready looks only at registered occupancy.
  always_comb begin
    ready    = '0;
    nonempty = '0;
    push     = '0;
    for (int s = 0; s < 2; s++) begin
      ready[s]    = !rst && (count[s] < CW'(DEPTH));
      nonempty[s] = (count[s] != '0);
      push[s]     = in_valid[s] && ready[s] && (in_addr[s] != 5'd0);
    end
    starved  = (starve_cnt >= SW'(STARVE_MAX));
    grant    = '0;
    grant[1] = nonempty[1] && (!nonempty[0] || starved);
    grant[0] = nonempty[0] && !grant[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        rd_ptr[s] <= '0;
        wr_ptr[s] <= '0;
        count[s]  <= '0;
      end
      starve_cnt <= '0;
      write_ena  <= 1'b0;
      write_addr <= 5'd0;
      write_data <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) begin
          fifo_addr[s][wr_ptr[s]] <= in_addr[s];
          fifo_data[s][wr_ptr[s]] <= in_data[s];
          wr_ptr[s]               <= wr_ptr[s] + PW'(1);
        end
        if (grant[s]) rd_ptr[s] <= rd_ptr[s] + PW'(1);
        case ({push[s], grant[s]})
          2'b10:   count[s] <= count[s] + CW'(1);
          2'b01:   count[s] <= count[s] - CW'(1);
          default: count[s] <= count[s];
        endcase
      end

      if (nonempty[1] && !grant[1]) begin
        if (!starved) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end

      write_ena <= |grant;
      if (grant[1]) begin
        write_addr <= fifo_addr[1][rd_ptr[1]];
        write_data <= fifo_data[1][rd_ptr[1]];
      end else if (grant[0]) begin
        write_addr <= fifo_addr[0][rd_ptr[0]];
        write_data <= fifo_data[0][rd_ptr[0]];
      end
    end
  end

  // Occupied slots are the count entries starting at the read pointer.
  always_comb begin
    logic [PW-1:0] offs;
    offs         = '0;
    pending_mask = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        offs = PW'(i) - rd_ptr[s];
        if (CW'(offs) < count[s]) pending_mask[fifo_addr[s][i]] = 1'b1;
      end
    end
    if (write_ena) pending_mask[write_addr] = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_writer.sv
// Randomized and directed bench for regfile_writer against a queue-based
// model of the two source FIFOs, the arbiter and the write port.
module tb_regfile_writer;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic            clk;
  logic            rst;
  logic            src0_valid, src1_valid;
  logic            src0_ready, src1_ready;
  logic [4:0]      src0_addr, src1_addr;
  logic [XLEN-1:0] src0_data, src1_data;
  logic [4:0]      write_addr;
  logic [XLEN-1:0] write_data;
  logic            write_ena;
  logic [31:0]     pending_mask;

  regfile_writer #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src0_addr(src0_addr), .src0_data(src0_data),
    .src1_valid(src1_valid), .src1_ready(src1_ready),
    .src1_addr(src1_addr), .src1_data(src1_data),
    .write_addr(write_addr), .write_data(write_data),
    .write_ena(write_ena), .pending_mask(pending_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file image as committed on the falling edge.
  logic [XLEN-1:0] rf [32];
  always @(negedge clk) if (write_ena === 1'b1) rf[write_addr] <= write_data;

  typedef struct {
    logic [4:0]      a;
    logic [XLEN-1:0] d;
  } ent_t;

  ent_t            q0[$];
  ent_t            q1[$];
  int              lost;
  logic            exp_ena;
  logic [4:0]      exp_addr;
  logic [XLEN-1:0] exp_data;
  int              n_checks;
  int              n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_pending();
    logic [31:0] m;
    m = '0;
    foreach (q0[i]) m[q0[i].a] = 1'b1;
    foreach (q1[i]) m[q1[i].a] = 1'b1;
    if (exp_ena) m[exp_addr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock of the model, using the inputs present at this edge.
  task automatic model_step();
    bit   acc0, acc1, g0, g1;
    ent_t e;
    if (rst) begin
      q0.delete();
      q1.delete();
      lost     = 0;
      exp_ena  = 1'b0;
      exp_addr = 5'd0;
      exp_data = '0;
      return;
    end
    acc0 = src0_valid && (q0.size() < DEPTH);
    acc1 = src1_valid && (q1.size() < DEPTH);
    g0 = 0;
    g1 = 0;
    if (q0.size() > 0 && q1.size() > 0) begin
      if (lost >= STARVE_MAX) g1 = 1; else g0 = 1;
    end else if (q0.size() > 0) g0 = 1;
    else if (q1.size() > 0) g1 = 1;
    if (q1.size() > 0 && !g1) lost = (lost < STARVE_MAX) ? lost + 1 : STARVE_MAX;
    else lost = 0;
    exp_ena = g0 | g1;
    if (g0) begin
      e = q0.pop_front();
      exp_addr = e.a;
      exp_data = e.d;
    end else if (g1) begin
      e = q1.pop_front();
      exp_addr = e.a;
      exp_data = e.d;
    end
    if (acc0 && src0_addr != 5'd0) q0.push_back('{a: src0_addr, d: src0_data});
    if (acc1 && src1_addr != 5'd0) q1.push_back('{a: src1_addr, d: src1_data});
  endtask

  task automatic compare();
    check("write_ena", 64'(write_ena), 64'(exp_ena));
    check("write_addr", 64'(write_addr), 64'(exp_addr));
    check("write_data", write_data, exp_data);
    check("pending_mask", 64'(pending_mask), 64'(exp_pending()));
    check("src0_ready", 64'(src0_ready), 64'(!rst && q0.size() < DEPTH));
    check("src1_ready", 64'(src1_ready), 64'(!rst && q1.size() < DEPTH));
    check("x0_write", 64'(write_ena && write_addr == 5'd0), 64'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [XLEN-1:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [XLEN-1:0] d1);
    src0_valid = v0; src0_addr = a0; src0_data = d0;
    src1_valid = v1; src1_addr = a1; src1_data = d1;
  endtask

  task automatic idle(input int n);
    drive(0, 5'd0, '0, 0, 5'd0, '0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Random pushes that never put the same register in flight from both sources.
  task automatic rand_drive();
    logic [31:0] busy;
    logic        v0, v1;
    logic [4:0]  a0, a1;
    busy = exp_pending();
    v0 = ($urandom_range(0, 3) != 0);
    v1 = ($urandom_range(0, 3) != 0);
    a0 = 5'($urandom_range(0, 31));
    a1 = 5'($urandom_range(0, 31));
    if (a0 != 5'd0 && busy[a0]) v0 = 0;
    if (a1 != 5'd0 && (busy[a1] || (v0 && a1 == a0))) v1 = 0;
    drive(v0, a0, {$urandom, $urandom}, v1, a1, {$urandom, $urandom});
    rst = ($urandom_range(0, 49) == 0);
  endtask

  int starve_seen;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    lost     = 0;
    exp_ena  = 0;
    exp_addr = 0;
    exp_data = 0;
    rst      = 1'b1;
    drive(0, 5'd0, '0, 0, 5'd0, '0);
    cycle();
    cycle();
    check("reset_ena", 64'(write_ena), 64'd0);
    check("reset_mask", 64'(pending_mask), 64'd0);
    check("reset_ready0", 64'(src0_ready), 64'd0);
    rst = 1'b0;
    cycle();

    // Single write and its latency.
    drive(1, 5'd5, 64'hDEAD, 0, 5'd0, '0);
    cycle();
    check("lat_pend_accept", 64'(pending_mask[5]), 64'd1);
    check("lat_ena_early", 64'(write_ena), 64'd0);
    drive(0, 5'd0, '0, 0, 5'd0, '0);
    cycle();
    check("lat_ena", 64'(write_ena), 64'd1);
    check("lat_addr", 64'(write_addr), 64'd5);
    check("lat_data", write_data, 64'hDEAD);
    check("lat_pend_write", 64'(pending_mask[5]), 64'd1);
    cycle();
    check("lat_ena_after", 64'(write_ena), 64'd0);
    check("lat_pend_after", 64'(pending_mask[5]), 64'd0);

    // x0 writes are accepted and dropped.
    drive(0, 5'd0, '0, 1, 5'd0, 64'h1234);
    cycle();
    check("x0_ready", 64'(src1_ready), 64'd1);
    check("x0_mask", 64'(pending_mask), 64'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("x0_no_write", 64'(write_ena), 64'd0);
    end

    // Starvation: src1 waits behind a continuous src0 stream.
    starve_seen = -1;
    for (int k = 0; k < 10; k++) begin
      drive(1, 5'(k + 1), 64'(k + 100), k == 0, 5'd20, 64'h2020);
      cycle();
      if (write_ena && write_addr == 5'd20 && starve_seen < 0) starve_seen = k;
      if (k == 5) check("full_ready0", 64'(src0_ready), 64'd0);
    end
    check("starve_grant_cycle", 64'(starve_seen), 64'd5);
    idle(4);

    // Reset while both FIFOs hold entries.
    for (int k = 0; k < 3; k++) begin
      drive(1, 5'(11 + k), 64'(k + 200), 1, 5'(21 + k), 64'(k + 300));
      cycle();
    end
    check("pre_rst_full1", 64'(src1_ready), 64'd0);
    drive(0, 5'd0, '0, 0, 5'd0, '0);
    rst = 1'b1;
    cycle();
    check("rst_mid_ena", 64'(write_ena), 64'd0);
    check("rst_mid_mask", 64'(pending_mask), 64'd0);
    check("rst_mid_ready", 64'(src0_ready), 64'd0);
    rst = 1'b0;
    cycle();
    check("rst_rel_ready", 64'(src0_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("rst_no_stale", 64'(write_ena), 64'd0);
    end

    // Streaming x1..x10 alternating sources.
    for (int i = 1; i <= 10; i++) begin
      if (i % 2 == 1) drive(1, 5'(i), 64'hA000 + 64'(i), 0, 5'd0, '0);
      else            drive(0, 5'd0, '0, 1, 5'(i), 64'hA000 + 64'(i));
      cycle();
      if (i >= 2) check("stream_rate", 64'(write_ena), 64'd1);
    end
    idle(4);
    for (int i = 1; i <= 10; i++) check("stream_rf", rf[i], 64'hA000 + 64'(i));

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rand_drive();
      cycle();
    end
    rst = 1'b0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
